// File: rtl/quantize_uv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quantize_uv_pkg
// Description : Shared constants, FSM state type and zigzag lookup for the
//               chroma quantizer.
// Revision    : 1.0 - initial release
// ============================================================================
package quantize_uv_pkg;

    // Fixed-point shift of the reciprocal quantizer step.
    localparam int QFIX        = 17;
    // Largest magnitude a level may take after clamping.
    localparam int MAX_LEVEL   = 2047;
    // Bits needed to hold a clamped level magnitude.
    localparam int LEVEL_BITS  = 11;
    // Coefficients in one 4x4 block.
    localparam int NUM_COEFFS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Raster position of zigzag index n.
    function automatic logic [3:0] zigzag(input logic [3:0] n);
        logic [3:0] j;
        case (n)
            4'd0:    j = 4'd0;
            4'd1:    j = 4'd1;
            4'd2:    j = 4'd4;
            4'd3:    j = 4'd8;
            4'd4:    j = 4'd5;
            4'd5:    j = 4'd2;
            4'd6:    j = 4'd3;
            4'd7:    j = 4'd6;
            4'd8:    j = 4'd9;
            4'd9:    j = 4'd12;
            4'd10:   j = 4'd13;
            4'd11:   j = 4'd10;
            4'd12:   j = 4'd7;
            4'd13:   j = 4'd11;
            4'd14:   j = 4'd14;
            default: j = 4'd15;
        endcase
        return j;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quantize_uv_quant_coeff.sv
`default_nettype none
// ============================================================================
// Module      : quant_coeff
// Description : One-coefficient quantizer. Stage 1 (registered here) forms
//               the magnitude, the reciprocal product and the zero-threshold
//               decision. Stage 2 (combinational here, registered by the
//               parent's output array) adds bias, shifts, clamps, restores
//               sign and dequantizes.
// Revision    : 1.0 - initial release
// ============================================================================
module quant_coeff
    import quantize_uv_pkg::*;
#(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 is_dc,
    input  logic [BIT_WIDTH-1:0] coeff,
    input  logic [15:0]          q_dc,
    input  logic [15:0]          q_ac,
    input  logic [31:0]          iq_dc,
    input  logic [31:0]          iq_ac,
    input  logic [31:0]          bias_dc,
    input  logic [31:0]          bias_ac,
    input  logic [15:0]          zthresh_dc,
    input  logic [15:0]          zthresh_ac,
    output logic [BIT_WIDTH-1:0] level,
    output logic [BIT_WIDTH-1:0] dq
);

    // One extra bit keeps |most negative| representable.
    logic [BIT_WIDTH:0]   ext_w;
    logic [BIT_WIDTH:0]   mag_w;
    logic                 sign_w;
    logic [15:0]          q_sel_w;
    logic [31:0]          iq_sel_w;
    logic [31:0]          bias_sel_w;
    logic [15:0]          zth_sel_w;

    logic [63:0]          prod_d, prod_q;
    logic                 sign_d, sign_q;
    logic                 above_d, above_q;

    logic [63:0]          sum_w;
    logic [63:0]          shifted_w;
    logic [LEVEL_BITS-1:0] lvl_clamp_w;
    logic [BIT_WIDTH-1:0] lvl_mag_w;
    logic [31:0]          lvl32_w;
    logic [31:0]          q32_w;

    // Stage 1: magnitude, reciprocal multiply and threshold compare.
    always_comb begin
        q_sel_w    = is_dc ? q_dc       : q_ac;
        iq_sel_w   = is_dc ? iq_dc      : iq_ac;
        bias_sel_w = is_dc ? bias_dc    : bias_ac;
        zth_sel_w  = is_dc ? zthresh_dc : zthresh_ac;

        sign_w  = coeff[BIT_WIDTH-1];
        ext_w   = {coeff[BIT_WIDTH-1], coeff};
        mag_w   = sign_w ? (~ext_w + 1'b1) : ext_w;

        prod_d  = prod_q;
        sign_d  = sign_q;
        above_d = above_q;
        if (en) begin
            prod_d  = 64'(mag_w) * 64'(iq_sel_w);
            sign_d  = sign_w;
            above_d = 64'(mag_w) > 64'(zth_sel_w);
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            sign_q  <= 1'b0;
            above_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            sign_q  <= sign_d;
            above_q <= above_d;
        end
    end

    // Stage 2: bias, shift, clamp, sign restore and dequantize.
    always_comb begin
        sum_w       = prod_q + 64'(bias_sel_w);
        shifted_w   = sum_w >> QFIX;
        lvl_clamp_w = (shifted_w > 64'(MAX_LEVEL)) ? LEVEL_BITS'(MAX_LEVEL)
                                                   : shifted_w[LEVEL_BITS-1:0];
        lvl_mag_w   = {{(BIT_WIDTH-LEVEL_BITS){1'b0}}, lvl_clamp_w};

        level = '0;
        if (above_q) begin
            level = sign_q ? (~lvl_mag_w + 1'b1) : lvl_mag_w;
        end

        // Product in 32 bits; the low BIT_WIDTH bits are the truncated dq.
        lvl32_w = 32'($signed(level));
        q32_w   = 32'(q_sel_w);
        dq      = BIT_WIDTH'($signed(lvl32_w) * $signed(q32_w));
    end

endmodule
`default_nettype wire

// File: rtl/quantize_uv.sv
`default_nettype none
// ============================================================================
// Module      : quantize_uv
// Description : Quantizes the 8 chroma 4x4 blocks of a macroblock into
//               zigzag-order levels, raster-order dequantized coefficients
//               and per-block nonzero flags. One block issues per cycle into
//               a two-stage datapath of 16 coefficient quantizers.
// Revision    : 1.0 - initial release
// ============================================================================
module quantize_uv
    import quantize_uv_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [BIT_WIDTH*16*BLOCK_SIZE-1:0]    coeffs,
    input  logic [15:0]                           q_dc,
    input  logic [15:0]                           q_ac,
    input  logic [31:0]                           iq_dc,
    input  logic [31:0]                           iq_ac,
    input  logic [31:0]                           bias_dc,
    input  logic [31:0]                           bias_ac,
    input  logic [15:0]                           zthresh_dc,
    input  logic [15:0]                           zthresh_ac,
    output logic [BIT_WIDTH*16*BLOCK_SIZE-1:0]    levels,
    output logic [BIT_WIDTH*16*BLOCK_SIZE-1:0]    dq_coeffs,
    output logic [BLOCK_SIZE-1:0]                 nz,
    output logic                                  busy,
    output logic                                  done
);

    localparam int BLK_W = BIT_WIDTH * NUM_COEFFS;
    localparam int BUS_W = BLK_W * BLOCK_SIZE;
    localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BLOCK = CNT_W'(BLOCK_SIZE - 1);

    state_t             state_d, state_q;
    logic [CNT_W-1:0]   count_d, count_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic               s1_valid_d, s1_valid_q;
    logic [CNT_W-1:0]   s1_block_d, s1_block_q;

    logic [BUS_W-1:0]   coeffs_cap_d, coeffs_cap_q;
    logic [15:0]        q_dc_d, q_dc_q, q_ac_d, q_ac_q;
    logic [31:0]        iq_dc_d, iq_dc_q, iq_ac_d, iq_ac_q;
    logic [31:0]        bias_dc_d, bias_dc_q, bias_ac_d, bias_ac_q;
    logic [15:0]        zth_dc_d, zth_dc_q, zth_ac_d, zth_ac_q;

    logic [BUS_W-1:0]      levels_d, levels_q;
    logic [BUS_W-1:0]      dq_d, dq_q;
    logic [BLOCK_SIZE-1:0] nz_d, nz_q;

    logic                  accept_w;
    logic                  issue_w;
    logic [BLK_W-1:0]      blk_coeffs_w;
    logic [BIT_WIDTH-1:0]  level_w [NUM_COEFFS];
    logic [BIT_WIDTH-1:0]  dqv_w   [NUM_COEFFS];
    logic                  blk_nz_w;

    assign accept_w     = (state_q == ST_IDLE) && start;
    assign issue_w      = (state_q == ST_RUN);
    assign blk_coeffs_w = coeffs_cap_q[int'(count_q)*BLK_W +: BLK_W];

    // Control: next state, block counter, capture of inputs on accept.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        done_d       = 1'b0;
        busy_d       = busy_q;
        s1_valid_d   = 1'b0;
        s1_block_d   = s1_block_q;
        coeffs_cap_d = coeffs_cap_q;
        q_dc_d       = q_dc_q;
        q_ac_d       = q_ac_q;
        iq_dc_d      = iq_dc_q;
        iq_ac_d      = iq_ac_q;
        bias_dc_d    = bias_dc_q;
        bias_ac_d    = bias_ac_q;
        zth_dc_d     = zth_dc_q;
        zth_ac_d     = zth_ac_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    coeffs_cap_d = coeffs;
                    q_dc_d       = q_dc;
                    q_ac_d       = q_ac;
                    iq_dc_d      = iq_dc;
                    iq_ac_d      = iq_ac;
                    bias_dc_d    = bias_dc;
                    bias_ac_d    = bias_ac;
                    zth_dc_d     = zthresh_dc;
                    zth_ac_d     = zthresh_ac;
                    count_d      = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                s1_valid_d = 1'b1;
                s1_block_d = count_q;
                if (count_q == LAST_BLOCK) begin
                    state_d = ST_FLUSH;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // Last block retires while s1_valid is still high.
                if (!s1_valid_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // busy covers the done cycle; a start right after done keeps it set.
        if (accept_w) begin
            busy_d = 1'b1;
        end else if (done_q) begin
            busy_d = 1'b0;
        end
    end

    // Control and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_block_q   <= '0;
            coeffs_cap_q <= '0;
            q_dc_q       <= '0;
            q_ac_q       <= '0;
            iq_dc_q      <= '0;
            iq_ac_q      <= '0;
            bias_dc_q    <= '0;
            bias_ac_q    <= '0;
            zth_dc_q     <= '0;
            zth_ac_q     <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            s1_valid_q   <= s1_valid_d;
            s1_block_q   <= s1_block_d;
            coeffs_cap_q <= coeffs_cap_d;
            q_dc_q       <= q_dc_d;
            q_ac_q       <= q_ac_d;
            iq_dc_q      <= iq_dc_d;
            iq_ac_q      <= iq_ac_d;
            bias_dc_q    <= bias_dc_d;
            bias_ac_q    <= bias_ac_d;
            zth_dc_q     <= zth_dc_d;
            zth_ac_q     <= zth_ac_d;
        end
    end

    generate
        for (genvar j = 0; j < NUM_COEFFS; j++) begin : g_coeff
            quant_coeff #(
                .BIT_WIDTH (BIT_WIDTH)
            ) u_quant_coeff (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (issue_w),
                .is_dc      (j == 0),
                .coeff      (blk_coeffs_w[j*BIT_WIDTH +: BIT_WIDTH]),
                .q_dc       (q_dc_q),
                .q_ac       (q_ac_q),
                .iq_dc      (iq_dc_q),
                .iq_ac      (iq_ac_q),
                .bias_dc    (bias_dc_q),
                .bias_ac    (bias_ac_q),
                .zthresh_dc (zth_dc_q),
                .zthresh_ac (zth_ac_q),
                .level      (level_w[j]),
                .dq         (dqv_w[j])
            );
        end
    endgenerate

    // Stage 2 write-back: retiring block lands in the output arrays.
    always_comb begin
        levels_d = levels_q;
        dq_d     = dq_q;
        nz_d     = nz_q;
        blk_nz_w = 1'b0;

        for (int j = 0; j < NUM_COEFFS; j++) begin
            blk_nz_w = blk_nz_w | (|level_w[j]);
        end

        if (accept_w) begin
            nz_d = '0;
        end

        if (s1_valid_q) begin
            for (int n = 0; n < NUM_COEFFS; n++) begin
                levels_d[(int'(s1_block_q)*NUM_COEFFS + n)*BIT_WIDTH +: BIT_WIDTH]
                    = level_w[zigzag(4'(n))];
                dq_d[(int'(s1_block_q)*NUM_COEFFS + n)*BIT_WIDTH +: BIT_WIDTH]
                    = dqv_w[n];
            end
            nz_d[s1_block_q] = blk_nz_w;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            levels_q <= '0;
            dq_q     <= '0;
            nz_q     <= '0;
        end else begin
            levels_q <= levels_d;
            dq_q     <= dq_d;
            nz_q     <= nz_d;
        end
    end

    assign levels    = levels_q;
    assign dq_coeffs = dq_q;
    assign nz        = nz_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: doc/quantize_uv.md
# quantize_uv

Quantizes the 8 chroma 4x4 blocks of one macroblock (4 U, then 4 V) from forward-transform coefficients into levels, and produces the matching dequantized coefficients and per-block nonzero flags. It sits directly upstream of the chroma cost stage (GetCostUV):
- `done` drives that stage's `start`.
- `levels` drives its `levels` bus, using the identical packing.

## Interface
Parameters:
- `BIT_WIDTH`, 16: width of one coefficient, level or dequantized value (signed).
- `BLOCK_SIZE`, 8: number of 4x4 blocks per invocation.

Ports (one clock, `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request; samples all data inputs
- `coeffs`  in  BIT_WIDTH*16*BLOCK_SIZE  raster-order coefficients; block i at [256i+255:256i], position j at [16j+15:16j] within the block
- `q_dc`, `q_ac`  in  16 each  quantizer step (position 0 / positions 1..15)
- `iq_dc`, `iq_ac`  in  32 each  reciprocal, (1<<17)/q
- `bias_dc`, `bias_ac`  in  32 each  rounding bias
- `zthresh_dc`, `zthresh_ac`  in  16 each  zero threshold
- `levels`  out  BIT_WIDTH*16*BLOCK_SIZE  zigzag-order levels; same block packing as `coeffs`, index n in place of j
- `dq_coeffs`  out  BIT_WIDTH*16*BLOCK_SIZE  raster-order dequantized coefficients
- `nz`  out  BLOCK_SIZE  bit i = block i has any nonzero level
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle pulse; outputs valid

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - `start`=1 captures `coeffs` and all quant parameters into registers.
  - Block counter resets to 0; go to RUN.
- RUN:
  - Issues block `count` into a 2-stage datapath each cycle.
  - After block 7, go to FLUSH.
- FLUSH:
  - Waits for the last block to retire.
  - Pulses `done` and returns to IDLE.
- `start` while `busy` is ignored. Captured data is not disturbed.
- Per coefficient at raster position j (n = zigzag index with kZigzag[n]=j); DC parameters apply for j=0, AC parameters for 1..15:
  - `mag` = |c| (17-bit unsigned, so that -32768 is safe); `sign` = c<0.
  - If `mag` > `zthresh`:
    - `lvl` = (`mag`*`iq` + `bias`) >> 17, computed in 64-bit unsigned.
    - Clamp `lvl` to 2047.
    - `level` = sign ? -`lvl` : `lvl`.
    - `dq` = `level`*`q`, truncated to BIT_WIDTH.
  - Else `level` = 0 and `dq` = 0.
  - `level` is written to levels slot n; `dq` is written to dq_coeffs slot j.
- `nz[i]` = OR of the 16 levels of block i, set when block i retires.
- Outputs hold their last values until the next accepted start.
- On an accepted start, `nz` is cleared. `levels` and `dq_coeffs` are overwritten block by block.

## Timing
- Reset values:
  - `levels`, `dq_coeffs`, `nz`: 0.
  - `busy`, `done`: 0.
  - State: IDLE; counter: 0.
- Let edge E0 sample `start`=1:
  - Blocks 0..7 are issued at edges E1..E8 (stage 1: magnitude, multiply, threshold compare, registered).
  - Blocks 0..7 retire at edges E2..E9 (stage 2: shift, clamp, sign, dequant, registered).
  - `done`=1 for exactly one cycle after edge E10.
- `busy` is high after E0 through the cycle in which `done` is high.
- A new start is accepted in the cycle after `done`. Minimum start-to-start spacing is 11 cycles.
- `rst_n` low mid-operation: all state and outputs clear immediately. No `done` is emitted for the aborted job.

## Structure
- Shared package holds:
  - The kZigzag table {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
  - `QFIX`=17.
  - `MAX_LEVEL`=2047.
- Sub-module `quant_coeff`: one coefficient, two pipeline stages, selectable DC/AC parameters. 16 instances are used, with the zigzag remap applied at the output write.
- The top level holds the FSM, block counter, input capture registers and output registers.

## Test plan
- All-zero `coeffs` -> `levels`=0, `dq_coeffs`=0, `nz`=0, `done` one cycle at E10.
- Block 0 DC coefficient = 100, with q_dc=8, iq_dc=16384, bias_dc=0, zthresh_dc=0 -> level slot 0 = 12, dq slot 0 = 96, `nz`=8'h01. Repeat with coefficient -100 -> level -12, dq -96.
- Block 5 position 4 = 50, with q_ac=1, iq_ac=131072, bias_ac=0, zthresh_ac=0 -> block 5 levels slot 2 = 50, dq slot 4 = 50, `nz`=8'h20.
- Coefficient 32767 with q=1, iq=131072 -> level 2047 (clamped). Coefficient equal to `zthresh` (e.g. 10 with zthresh 10) -> level 0, dq 0.
- Second `start` at E3 -> ignored; single `done` at E10 with the first job's results. A new start at E11 is accepted.
- `rst_n` pulsed low at E5 -> outputs 0 immediately, no `done`. A fresh start afterwards completes normally.
